// File: rtl/vend_pkg.sv
// Shared types and constants for the vend_sequencer block: FSM state
// encoding, coin_type encodings and coin values in quarter units.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    VEND      = 2'd1,
    CHG_WAIT  = 2'd2,
    CHG_PULSE = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_QUARTER = 2'b01;
  localparam logic [1:0] COIN_HALF    = 2'b10;
  localparam logic [1:0] COIN_DOLLAR  = 2'b11;

  localparam logic [3:0] VAL_QUARTER = 4'd1;
  localparam logic [3:0] VAL_HALF    = 4'd2;
  localparam logic [3:0] VAL_DOLLAR  = 4'd4;

  // Credit value of a coin in quarter units; "none" is worth nothing.
  function automatic logic [3:0] coin_value(input logic [1:0] coin_type);
    case (coin_type)
      COIN_QUARTER: return VAL_QUARTER;
      COIN_HALF:    return VAL_HALF;
      COIN_DOLLAR:  return VAL_DOLLAR;
      default:      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_sequencer_if.sv
// Coin/dispense/status bundle for vend_sequencer. The slave modport is the
// sequencer itself; the master modport is whatever drives coins and the hopper.
interface vend_sequencer_if;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       refund_req;
  logic       hopper_ready;
  logic       guffin_out;
  logic       quarter_out;
  logic       halfDollar_out;
  logic [3:0] credit_q;
  logic [2:0] state_code;
  logic       busy;

  modport master (
    output coin_valid, coin_type, refund_req, hopper_ready,
    input  coin_ready, guffin_out, quarter_out, halfDollar_out,
           credit_q, state_code, busy
  );

  modport slave (
    input  coin_valid, coin_type, refund_req, hopper_ready,
    output coin_ready, guffin_out, quarter_out, halfDollar_out,
           credit_q, state_code, busy
  );
endinterface

// File: rtl/vend_sequencer_pulse_timer.sv
// pulse_timer: loads PULSE_W and counts down to zero. active is high while
// the count is nonzero; last marks the final cycle of the pulse so the owner
// can drop its output on the same edge the count reaches zero.
module pulse_timer #(
  parameter int PULSE_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic active,
  output logic last
);

  logic [3:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= 4'(PULSE_W);
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign active = (count != 4'd0);
  assign last   = (count == 4'd1);

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: accepts coins, dispenses an item once credit reaches
// PRICE_Q, then pays change back as half-dollar/quarter pulses gated by the
// hopper. Optional build macro VEND_REFUND_EN adds a customer refund path
// from COLLECT; without it refund_req is ignored.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE_Q = 6,
  parameter int PULSE_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  vend_sequencer_if.slave bus
);

  localparam logic [3:0] PRICE = 4'(PRICE_Q);

  state_t     state;
  logic [3:0] credit;
  logic       guffin_r;
  logic       quarter_r;
  logic       half_r;

  logic       coin_take;
  logic [3:0] credit_sum;
  logic       vend_now;
  logic       chg_now;
  logic       refund_take;
  logic       timer_load;
  logic       timer_active;
  logic       timer_last;
  logic       pulse_end;

  assign coin_take  = bus.coin_valid && (state == COLLECT) && (bus.coin_type != COIN_NONE);
  assign credit_sum = credit + (coin_take ? coin_value(bus.coin_type) : 4'd0);
  assign vend_now   = (state == COLLECT) && (credit_sum >= PRICE);
  assign chg_now    = (state == CHG_WAIT) && bus.hopper_ready;
  assign timer_load = vend_now || chg_now;
  assign pulse_end  = timer_active && timer_last;

`ifdef VEND_REFUND_EN
  assign refund_take = bus.refund_req && (credit_sum != 4'd0);
`else
  logic unused_refund;
  assign unused_refund = bus.refund_req;
  assign refund_take   = 1'b0;
`endif

  pulse_timer #(.PULSE_W(PULSE_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .active (timer_active),
    .last   (timer_last)
  );

  // Main sequencer: state, credit and the registered dispense outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      credit    <= 4'd0;
      guffin_r  <= 1'b0;
      quarter_r <= 1'b0;
      half_r    <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          credit <= credit_sum;
          if (vend_now) begin
            state    <= VEND;
            guffin_r <= 1'b1;
          end else if (refund_take) begin
            state <= CHG_WAIT;
          end
        end
        VEND: begin
          if (pulse_end) begin
            guffin_r <= 1'b0;
            credit   <= credit - PRICE;
            state    <= (credit > PRICE) ? CHG_WAIT : COLLECT;
          end
        end
        CHG_WAIT: begin
          if (bus.hopper_ready) begin
            state <= CHG_PULSE;
            if (credit >= VAL_HALF) begin
              half_r <= 1'b1;
              credit <= credit - VAL_HALF;
            end else begin
              quarter_r <= 1'b1;
              credit    <= credit - VAL_QUARTER;
            end
          end
        end
        CHG_PULSE: begin
          if (pulse_end) begin
            half_r    <= 1'b0;
            quarter_r <= 1'b0;
            state     <= (credit != 4'd0) ? CHG_WAIT : COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.coin_ready     = (state == COLLECT);
  assign bus.busy           = (state != COLLECT);
  assign bus.state_code     = {1'b0, state};
  assign bus.credit_q       = credit;
  assign bus.guffin_out     = guffin_r;
  assign bus.quarter_out    = quarter_r;
  assign bus.halfDollar_out = half_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer (PRICE_Q=6, PULSE_W=4). A table of
// coin sequences drives the main vend/change behaviour; each expected
// dispense pulse is queued when coins go in and matched by a pulse monitor.
// Hand-written sequences cover hopper stall, dropped coins, reset mid-pulse
// and the VEND_REFUND_EN refund path.
module tb_vend_sequencer;
  import vend_pkg::*;

  localparam int PRICE_Q = 6;
  localparam int PULSE_W = 4;
  localparam int EV_G = 0;
  localparam int EV_H = 1;
  localparam int EV_Q = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  vend_sequencer_if bus();

  vend_sequencer #(.PRICE_Q(PRICE_Q), .PULSE_W(PULSE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int run_len[3];
  int credit_m = 0;

  typedef struct {
    logic [5:0] coins;
    int         n_coins;
    int         vend;
    int         n_half;
    int         n_quarter;
    int         final_credit;
  } vec_t;

  vec_t vecs[8];

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int tb_value(input logic [1:0] t);
    case (t)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  // Pulse monitor: measures each dispense pulse and matches it to the queue.
  always @(negedge clk or negedge rst_n) begin : monitor
    logic [2:0] outs;
    int e;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) run_len[i] = 0;
    end else begin
      outs = {bus.quarter_out, bus.halfDollar_out, bus.guffin_out};
      if (outs != 3'b000) check_output("one_output_at_a_time", $countones(outs), 1);
      for (int i = 0; i < 3; i++) begin
        if (outs[i]) begin
          run_len[i]++;
        end else if (run_len[i] > 0) begin
          if (exp_q.size() == 0) begin
            check_output("unexpected_pulse_kind", i, -1);
          end else begin
            e = exp_q.pop_front();
            check_output("pulse_kind", i, e);
          end
          check_output("pulse_width", run_len[i], PULSE_W);
          run_len[i] = 0;
        end
      end
    end
  end

  // One coin for one cycle, returning at the negedge after it was sampled.
  task automatic apply_stimulus(input logic [1:0] t);
    @(negedge clk);
    bus.coin_valid = 1'b1;
    bus.coin_type  = t;
    @(negedge clk);
    bus.coin_valid = 1'b0;
    bus.coin_type  = COIN_NONE;
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (int'(bus.state_code) == code) break;
      @(negedge clk);
    end
    check_output(name, int'(bus.state_code), code);
  endtask

  task automatic wait_idle(input string name);
    wait_state(0, 200, name);
    repeat (3) @(negedge clk);
    check_output({name, "_pending_pulses"}, exp_q.size(), 0);
  endtask

  task automatic push_events(input int n_g, input int n_h, input int n_q);
    for (int i = 0; i < n_g; i++) exp_q.push_back(EV_G);
    for (int i = 0; i < n_h; i++) exp_q.push_back(EV_H);
    for (int i = 0; i < n_q; i++) exp_q.push_back(EV_Q);
  endtask

  task automatic coin_and_check(input logic [1:0] t, input string name);
    apply_stimulus(t);
    credit_m += tb_value(t);
    check_output(name, int'(bus.credit_q), credit_m);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.coin_valid   = 1'b0;
    bus.coin_type    = COIN_NONE;
    bus.refund_req   = 1'b0;
    bus.hopper_ready = 1'b1;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_state_code", int'(bus.state_code), 0);
    check_output("reset_credit", int'(bus.credit_q), 0);
    check_output("reset_busy", int'(bus.busy), 0);
    check_output("reset_coin_ready", int'(bus.coin_ready), 1);
    check_output("reset_outputs", int'({bus.guffin_out, bus.halfDollar_out, bus.quarter_out}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // coins packed {c2, c1, c0}, c0 inserted first
    vecs[0] = '{{2'b00, 2'b10, 2'b11}, 2, 1, 0, 0, 0};
    vecs[1] = '{{2'b00, 2'b11, 2'b11}, 2, 1, 1, 0, 0};
    vecs[2] = '{{2'b11, 2'b10, 2'b10}, 3, 1, 1, 0, 0};
    vecs[3] = '{{2'b01, 2'b11, 2'b01}, 3, 1, 0, 0, 0};
    vecs[4] = '{{2'b10, 2'b10, 2'b10}, 3, 1, 0, 0, 0};
    vecs[5] = '{{2'b11, 2'b01, 2'b11}, 3, 1, 1, 1, 0};
    vecs[6] = '{{2'b01, 2'b00, 2'b01}, 3, 0, 0, 0, 2};
    vecs[7] = '{{2'b00, 2'b00, 2'b11}, 1, 1, 0, 0, 0};

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].vend != 0) push_events(1, vecs[v].n_half, vecs[v].n_quarter);
      for (int c = 0; c < vecs[v].n_coins; c++) begin
        coin_and_check(vecs[v].coins[2*c +: 2], "vec_credit_after_coin");
      end
      if (vecs[v].vend != 0) begin
        check_output("vec_enter_vend", int'(bus.state_code), 1);
        check_output("vec_coin_ready_in_vend", int'(bus.coin_ready), 0);
        wait_idle("vec_back_to_collect");
      end
      check_output("vec_final_credit", int'(bus.credit_q), vecs[v].final_credit);
      credit_m = vecs[v].final_credit;
    end

    // Hopper stalls change: FSM must hold CHG_WAIT with nothing dispensed.
    bus.hopper_ready = 1'b0;
    push_events(1, 1, 0);
    coin_and_check(2'b10, "hop_credit");
    coin_and_check(2'b10, "hop_credit");
    coin_and_check(2'b11, "hop_credit");
    wait_state(2, 50, "hop_reach_chg_wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("hop_hold_no_change",
                   int'({bus.state_code, bus.halfDollar_out, bus.quarter_out}), 8);
    end
    check_output("hop_credit_held", int'(bus.credit_q), 2);
    bus.hopper_ready = 1'b1;
    wait_idle("hop_done");
    check_output("hop_final_credit", int'(bus.credit_q), 0);
    credit_m = 0;

    // Coins offered during VEND and CHG_PULSE are dropped.
    push_events(1, 1, 0);
    coin_and_check(2'b11, "drop_credit");
    coin_and_check(2'b11, "drop_credit");
    bus.coin_valid = 1'b1;
    bus.coin_type  = 2'b11;
    @(negedge clk);
    bus.coin_valid = 1'b0;
    bus.coin_type  = COIN_NONE;
    check_output("drop_in_vend_credit", int'(bus.credit_q), 8);
    check_output("drop_in_vend_ready", int'(bus.coin_ready), 0);
    wait_state(3, 50, "drop_reach_chg_pulse");
    bus.coin_valid = 1'b1;
    bus.coin_type  = 2'b01;
    @(negedge clk);
    bus.coin_valid = 1'b0;
    bus.coin_type  = COIN_NONE;
    check_output("drop_in_chg_pulse_credit", int'(bus.credit_q), 0);
    check_output("drop_in_chg_pulse_ready", int'(bus.coin_ready), 0);
    wait_idle("drop_done");
    credit_m = 0;

    // Reset in the second cycle of a half-dollar pulse truncates it.
    push_events(1, 0, 0);
    coin_and_check(2'b11, "rst_credit");
    coin_and_check(2'b11, "rst_credit");
    for (int i = 0; i < 50; i++) begin
      if (bus.halfDollar_out) break;
      @(negedge clk);
    end
    check_output("rst_half_started", int'(bus.halfDollar_out), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst_half_cut", int'(bus.halfDollar_out), 0);
    check_output("rst_state_code", int'(bus.state_code), 0);
    check_output("rst_credit_zero", int'(bus.credit_q), 0);
    check_output("rst_busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_after_release_state", int'(bus.state_code), 0);
    check_output("rst_after_release_credit", int'(bus.credit_q), 0);
    check_output("rst_pending_pulses", exp_q.size(), 0);
    credit_m = 0;
    push_events(1, 0, 0);
    coin_and_check(2'b11, "resume_credit");
    coin_and_check(2'b10, "resume_credit");
    wait_idle("resume_done");

    // Refund with zero credit is always ignored.
    @(negedge clk);
    bus.refund_req = 1'b1;
    @(negedge clk);
    bus.refund_req = 1'b0;
    check_output("refund_zero_ignored", int'(bus.state_code), 0);

    // Refund with credit 3.
    credit_m = 0;
    coin_and_check(2'b01, "refund_credit");
    coin_and_check(2'b10, "refund_credit");
`ifdef VEND_REFUND_EN
    push_events(0, 1, 1);
`endif
    @(negedge clk);
    bus.refund_req = 1'b1;
    @(negedge clk);
    bus.refund_req = 1'b0;
`ifdef VEND_REFUND_EN
    check_output("refund_enter_chg_wait", int'(bus.state_code), 2);
    wait_idle("refund_done");
    check_output("refund_final_credit", int'(bus.credit_q), 0);
`else
    repeat (3) @(negedge clk);
    check_output("refund_ignored_state", int'(bus.state_code), 0);
    check_output("refund_ignored_credit", int'(bus.credit_q), 3);
`endif

    repeat (3) @(negedge clk);
    check_output("final_pending_pulses", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
